r4_booth_mul_pipe: RTL
======================

// Module: r4_booth_mul_pipe
// PURPOSE
//   Parametrised, pipelined radix-4 Booth multiplier for the Kulisch-accumulator
//   datapath. Accepts one mx*my operand pair per cycle under valid/ready flow
//   control, in signed or unsigned mode per transaction. Returns the carry-save
//   pair (sum, carry) for direct merge into the accumulator CSA, plus the resolved
//   product. Generalises the fixed 11-bit combinational Booth multiplier.
// PARAMETERS
//   WIDTH  11  operand width in bits, 4..32; product width is 2*WIDTH
//   TAG_W  4   width of the sideband tag carried alongside each transaction
// PORTS
//   CLK        in   1        clock, rising edge
//   RST        in   1        reset, asynchronous assert, active-low (0 = reset)
//   in_valid   in   1        operand pair valid
//   in_ready   out  1        block can accept the operand pair this cycle
//   in_signed  in   1        1: mx/my two's complement; 0: unsigned
//   in_mx      in   WIDTH    multiplier; Booth-recoded operand
//   in_my      in   WIDTH    multiplicand
//   in_tag     in   TAG_W    sideband; returned unchanged with the result
//   out_valid  out  1        result valid
//   out_ready  in   1        downstream accepts the result
//   out_sum    out  2*WIDTH  carry-save sum vector
//   out_carry  out  2*WIDTH  carry-save carry vector, already weight-aligned
//   out_prod   out  2*WIDTH  resolved product, equal to (out_sum + out_carry) mod 2^(2W)
//   out_tag    out  TAG_W    tag of the transaction on the output
// BEHAVIOUR
// - Operand extension: extend each operand to WIDTH+1 bits, sign-extending when
//   in_signed=1 and zero-extending when in_signed=0.
// - Group count: G = ceil((WIDTH+1)/2). Booth triplets start at bit 0 with an
//   implicit 0 below bit 0 and are padded with the extension bit at the top.
// - Partial products: digit values in {-2,-1,0,+1,+2}. Each partial product uses
//   the sign-extension-bit scheme (~e in PP0, e in the others, neg bit injected at
//   the LSB of its group). The pos-zero and neg-zero Booth codes force the
//   correct e.
// - S1 (register): Booth encode, partial-product generation, in_signed and tag.
// - S2 (register): Wallace/Dadda 3:2 reduction to out_sum/out_carry.
//   - Truncate modulo 2^(2W).
//   - Mathematical identity required: sum + carry == mx*my (mod 2^(2W)).
// - S3 (register): out_prod = sum + carry via a 2W-bit CPA. out_sum and out_carry
//   are the S2 values re-registered alongside it.
// - Latency: exactly 3 cycles, from the in_valid&&in_ready edge to out_valid,
//   when there is no backpressure. Throughput is 1 transaction per cycle.
// - Flow control: each stage k holds v_k and ready_k = !v_k || ready_{k+1},
//   with ready_4 = out_ready and in_ready = ready_1.
//   - A stage loads only when ready_k is 1; a stalled stage holds its data bit-exact.
//   - in_ready is combinational from out_ready through the valid chain.
//   - in_ready does not depend on in_valid.
// - Handshake rules:
//   - When out_valid=1 and out_ready=0, all out_* stay stable until accepted.
//   - in_valid=1 with in_ready=0 is ignored: no capture; upstream must hold.
//   - Simultaneous accept at the output and capture at the input in a full pipe
//     is legal with no bubble.
// - Reset: when RST=0, all valid bits and all data/tag registers are cleared
//   asynchronously.
//   - Outputs during reset: out_valid=0, out_sum=out_carry=out_prod=0, out_tag=0.
//   - in_ready is 1 in the cycle after release.
//   - Reset mid-operation discards every in-flight transaction. There is no
//     partial output.
// - Boundary values that must be exact:
//   - signed: (-2^(W-1))*(-2^(W-1)) = 2^(2W-2)
//   - unsigned: (2^W-1)^2
//   - zero in either operand gives 0
// TESTING
// - T1 W=11 signed: mx=-1024, my=-1024 -> out_prod=0x100000 at cycle+3; (out_sum+out_carry) mod 2^22 matches.
// - T2 W=11 unsigned: mx=my=2047 -> out_prod=4190209. The same bits in signed mode -> out_prod=1.
// - T3 back-to-back: 64 random pairs, in_valid held high, out_ready=1, random modes -> one result per cycle, in order, tags match, all equal to the reference model.
// - T4 backpressure: out_ready toggled at random (about 50%) -> no loss, duplication or reordering; outputs stable while stalled; in_ready falls only when all 3 stages are full.
// - T5 reset mid-flight: 3 transactions in the pipe, RST=0 for 1 cycle -> out_valid=0 immediately and outputs zero; none of the 3 results ever appears.
// - T6 sweep: WIDTH=4 exhaustive and WIDTH=16 (1e5 random vectors), both modes -> zero mismatches, including operands 0, -1 and the most negative value.

Source files
------------

// File: rtl/r4_booth_mul_pipe.sv
// r4_booth_mul_pipe: three-stage radix-4 Booth multiplier with valid/ready flow control.
// Returns the carry-save pair (sum, carry) and the resolved product with a passthrough tag.
module r4_booth_mul_pipe #(
    parameter int unsigned WIDTH = 11,
    parameter int unsigned TAG_W = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_signed,
    input  logic [WIDTH-1:0]   in_mx,
    input  logic [WIDTH-1:0]   in_my,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_sum,
    output logic [2*WIDTH-1:0] out_carry,
    output logic [2*WIDTH-1:0] out_prod,
    output logic [TAG_W-1:0]   out_tag
);
    localparam int unsigned P = 2 * WIDTH;
    localparam int unsigned N = WIDTH + 1;
    localparam int unsigned L = N + 1;
    localparam int unsigned G = (N + 1) / 2;
    localparam int unsigned R = G + 2;

    // Each PP row carries ~e at bit L (a +2^L bias); this constant removes all biases.
    function automatic logic [P-1:0] sign_corr();
        logic [P-1:0] acc;
        logic [P-1:0] one;
        acc    = '0;
        one    = '0;
        one[0] = 1'b1;
        for (int unsigned j = 0; j < G; j++) begin
            acc = acc + (one << (L + 2 * j));
        end
        return ~acc + one;
    endfunction

    localparam logic [P-1:0] CORR = sign_corr();

    logic             v1_q, v2_q, v3_q;
    logic             rdy1, rdy2, rdy3;
    logic [P-1:0]     rows_d [R];
    logic [P-1:0]     rows_q [R];
    logic [TAG_W-1:0] tag1_q, tag2_q, tag3_q;
    logic [P-1:0]     sum_d, carry_d, prod_d;
    logic [P-1:0]     sum2_q, carry2_q;
    logic [P-1:0]     sum3_q, carry3_q, prod3_q;

    assign rdy3     = !v3_q || out_ready;
    assign rdy2     = !v2_q || rdy3;
    assign rdy1     = !v1_q || rdy2;
    assign in_ready = rdy1;

    always_comb begin : booth_enc
        logic           ex;
        logic           ey;
        logic [2*G:0]   mxp;
        logic [N-1:0]   myx;
        logic [2:0]     trip;
        logic           neg;
        logic           one;
        logic           two;
        logic [L-1:0]   mag;
        logic [L-1:0]   ppb;
        logic [P-1:0]   row;
        logic [P-1:0]   negrow;
        rows_d = '{default: '0};
        ex     = in_signed & in_mx[WIDTH-1];
        ey     = in_signed & in_my[WIDTH-1];
        mxp    = {{(2 * G - WIDTH){ex}}, in_mx, 1'b0};
        myx    = {ey, in_my};
        negrow = '0;
        trip   = '0;
        neg    = 1'b0;
        one    = 1'b0;
        two    = 1'b0;
        mag    = '0;
        ppb    = '0;
        row    = '0;
        for (int unsigned j = 0; j < G; j++) begin
            trip = mxp[2 * j +: 3];
            // 111 (neg-zero) decodes like 000 so its row and e stay zero
            neg  = trip[2] & ~(trip[1] & trip[0]);
            one  = trip[1] ^ trip[0];
            two  = (trip == 3'b011) || (trip == 3'b100);
            if (one) begin
                mag = {myx[N-1], myx};
            end else if (two) begin
                mag = {myx, 1'b0};
            end else begin
                mag = '0;
            end
            ppb         = neg ? ~mag : mag;
            row         = '0;
            row[L:0]    = {~ppb[L-1], ppb};
            rows_d[j]   = row << (2 * j);
            negrow[2*j] = neg;
        end
        rows_d[G]   = negrow;
        rows_d[G+1] = CORR;
    end

    // Wallace-style reduction: every level compresses each full triple of rows with a 3:2 CSA.
    always_comb begin : csa_tree
        logic [P-1:0] lvl [R];
        logic [P-1:0] nxt [R];
        int unsigned  n;
        int unsigned  m;
        lvl = rows_q;
        nxt = '{default: '0};
        n   = R;
        m   = 0;
        for (int unsigned lev = 0; lev < R; lev++) begin
            if (n > 2) begin
                nxt = '{default: '0};
                m   = 0;
                for (int unsigned i = 0; i < R; i += 3) begin
                    if (i + 2 < n) begin
                        nxt[m]   = lvl[i] ^ lvl[i+1] ^ lvl[i+2];
                        nxt[m+1] = ((lvl[i] & lvl[i+1]) | (lvl[i] & lvl[i+2])
                                   | (lvl[i+1] & lvl[i+2])) << 1;
                        m        = m + 2;
                    end else begin
                        if (i < n) begin
                            nxt[m] = lvl[i];
                            m      = m + 1;
                        end
                        if (i + 1 < n) begin
                            nxt[m] = lvl[i+1];
                            m      = m + 1;
                        end
                    end
                end
                lvl = nxt;
                n   = m;
            end
        end
        sum_d   = lvl[0];
        carry_d = lvl[1];
    end

    assign prod_d = sum2_q + carry2_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            v3_q     <= 1'b0;
            rows_q   <= '{default: '0};
            tag1_q   <= '0;
            tag2_q   <= '0;
            tag3_q   <= '0;
            sum2_q   <= '0;
            carry2_q <= '0;
            sum3_q   <= '0;
            carry3_q <= '0;
            prod3_q  <= '0;
        end else begin
            if (rdy1) begin
                v1_q <= in_valid;
                if (in_valid) begin
                    rows_q <= rows_d;
                    tag1_q <= in_tag;
                end
            end
            if (rdy2) begin
                v2_q <= v1_q;
                if (v1_q) begin
                    sum2_q   <= sum_d;
                    carry2_q <= carry_d;
                    tag2_q   <= tag1_q;
                end
            end
            if (rdy3) begin
                v3_q <= v2_q;
                if (v2_q) begin
                    sum3_q   <= sum2_q;
                    carry3_q <= carry2_q;
                    prod3_q  <= prod_d;
                    tag3_q   <= tag2_q;
                end
            end
        end
    end

    assign out_valid = v3_q;
    assign out_sum   = sum3_q;
    assign out_carry = carry3_q;
    assign out_prod  = prod3_q;
    assign out_tag   = tag3_q;

endmodule
